// File: rtl/video_pll_pkg.sv
// Shared types and default constants for the video PLL reset sequencer.
// No logic: state encoding, default cycle counts and a sizing helper.
// Imported by the sequencer top.
package video_pll_pkg;

    localparam int NUM_VIDEO_CLOCKS            = 3;
    localparam int DEF_SYNC_STAGES             = 2;
    localparam int DEF_PLL_RST_CYCLES          = 16;
    localparam int DEF_LOCK_STABLE_CYCLES      = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYCLES     = 500000;
    localparam int DEF_DOMAIN_GAP_CYCLES       = 64;
    localparam int DEF_MAX_RETRIES             = 7;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        FAIL      = 3'd5
    } pll_state_t;

    // Largest of the cycle parameters; sizes the shared state counter.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/video_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level into the clk domain.
// Latency: SYNC_STAGES clk cycles from input change to output change.
// No backpressure; output resets to 0 asynchronously.
module video_sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    // Shift the asynchronous level through the synchronizer chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/video_pll_reset_sequencer.sv
// Drives PLL reset, qualifies lock, then releases domain resets in staggered index order.
// Latency: all outputs registered; lock reaction SYNC_STAGES+1 cycles after pll_locked changes.
// No backpressure; soft_reset_req restarts the sequence and overrides every other event.
module video_pll_reset_sequencer
    import video_pll_pkg::*;
#(
    parameter int NUM_DOMAINS         = NUM_VIDEO_CLOCKS,
    parameter int SYNC_STAGES         = DEF_SYNC_STAGES,
    parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int DOMAIN_GAP_CYCLES   = DEF_DOMAIN_GAP_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic                   refclk,
    input  logic                   rst,
    input  logic                   pll_locked,
    input  logic                   soft_reset_req,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_rst,
    output logic                   ready,
    output logic                   lock_lost,
    output logic [2:0]             retry_count,
    output logic                   fail
);

    localparam int CNT_MAX = max4(PLL_RST_CYCLES, LOCK_STABLE_CYCLES,
                                  LOCK_TIMEOUT_CYCLES, DOMAIN_GAP_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int DOM_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(DOMAIN_GAP_CYCLES - 1);
    localparam logic [DOM_W-1:0] DOM_LAST     = DOM_W'(NUM_DOMAINS - 1);
    localparam logic [2:0]       RETRY_MAX    = 3'(MAX_RETRIES);

    pll_state_t             r_state;
    pll_state_t             w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [DOM_W-1:0]       r_dom;
    logic [DOM_W-1:0]       w_dom_nxt;
    logic [2:0]             w_retry_nxt;
    logic                   w_lock_lost_nxt;
    logic                   w_pll_rst_nxt;
    logic [NUM_DOMAINS-1:0] w_domain_rst_nxt;
    logic                   w_ready_nxt;
    logic                   w_fail_nxt;
    logic                   w_lock_s;
    logic                   w_gap_done;
    logic                   w_entry;

    video_sync_bit #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .i_d (pll_locked),
        .o_q (w_lock_s)
    );

    assign w_gap_done = (r_cnt == GAP_LAST);

    // State register.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state <= PLL_RST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; a soft reset request overrides every other event.
    always_comb begin
        w_state_nxt = r_state;
        if (soft_reset_req) begin
            w_state_nxt = PLL_RST;
        end else begin
            case (r_state)
                PLL_RST: begin
                    if (r_cnt == PLL_RST_LAST) w_state_nxt = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (w_lock_s) begin
                        w_state_nxt = STABLE;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        w_state_nxt = (retry_count < RETRY_MAX) ? PLL_RST : FAIL;
                    end
                end
                STABLE: begin
                    if (!w_lock_s)                  w_state_nxt = WAIT_LOCK;
                    else if (r_cnt == STABLE_LAST)  w_state_nxt = RELEASE;
                end
                RELEASE: begin
                    if (!w_lock_s)                          w_state_nxt = PLL_RST;
                    else if (w_gap_done && r_dom == DOM_LAST) w_state_nxt = RUN;
                end
                RUN: begin
                    if (!w_lock_s) w_state_nxt = PLL_RST;
                end
                FAIL: begin
                    w_state_nxt = FAIL;
                end
                default: begin
                    w_state_nxt = PLL_RST;
                end
            endcase
        end
    end

    // Next values for counters, status and the registered outputs.
    always_comb begin
        w_entry          = soft_reset_req || (w_state_nxt != r_state);
        w_cnt_nxt        = r_cnt;
        w_dom_nxt        = r_dom;
        w_retry_nxt      = retry_count;
        w_lock_lost_nxt  = lock_lost;
        w_domain_rst_nxt = '1;

        // Shared counter: cleared on every state entry and on each release step.
        if (w_entry) begin
            w_cnt_nxt = '0;
        end else if (r_state == RELEASE && w_gap_done) begin
            w_cnt_nxt = '0;
        end else if (r_state != RUN && r_state != FAIL) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end

        // Domain index only advances while staying inside RELEASE.
        if (w_state_nxt != RELEASE || r_state != RELEASE) begin
            w_dom_nxt = '0;
        end else if (w_gap_done) begin
            w_dom_nxt = r_dom + 1'b1;
        end

        if (soft_reset_req) begin
            w_retry_nxt     = '0;
            w_lock_lost_nxt = 1'b0;
        end else begin
            // WAIT_LOCK -> PLL_RST without soft reset is always a counted timeout.
            if (r_state == WAIT_LOCK && w_state_nxt == PLL_RST) begin
                w_retry_nxt = retry_count + 3'd1;
            end
            if ((r_state == RELEASE || r_state == RUN) && !w_lock_s) begin
                w_lock_lost_nxt = 1'b1;
            end
        end

        case (w_state_nxt)
            RELEASE: begin
                for (int i = 0; i < NUM_DOMAINS; i++) begin
                    w_domain_rst_nxt[i] = (i > int'(w_dom_nxt));
                end
            end
            RUN:     w_domain_rst_nxt = '0;
            default: w_domain_rst_nxt = '1;
        endcase

        w_pll_rst_nxt = (w_state_nxt == PLL_RST);
        w_ready_nxt   = (w_state_nxt == RUN);
        w_fail_nxt    = (w_state_nxt == FAIL);
    end

    // Counters, status and output registers.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_dom       <= '0;
            pll_rst     <= 1'b1;
            domain_rst  <= '1;
            ready       <= 1'b0;
            lock_lost   <= 1'b0;
            retry_count <= '0;
            fail        <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_dom       <= w_dom_nxt;
            pll_rst     <= w_pll_rst_nxt;
            domain_rst  <= w_domain_rst_nxt;
            ready       <= w_ready_nxt;
            lock_lost   <= w_lock_lost_nxt;
            retry_count <= w_retry_nxt;
            fail        <= w_fail_nxt;
        end
    end

endmodule

// File: tb/tb_video_pll_reset_sequencer.sv
module tb_video_pll_reset_sequencer;

    typedef struct packed {
        logic       pr;
        logic [2:0] dr;
        logic       rdy;
        logic       ll;
        logic [2:0] rc;
        logic       fl;
    } out_t;

    typedef struct {
        bit    rs;
        int    d;
        bit    lk;
        bit    sf;
        int    c;
        out_t  e;
        string nm;
    } vec_t;

    typedef struct {
        int    cyc;
        out_t  e;
        string nm;
    } sb_t;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       soft_reset_req = 1'b0;
    logic       pll_rst;
    logic [2:0] domain_rst;
    logic       ready;
    logic       lock_lost;
    logic [2:0] retry_count;
    logic       fail;

    int   cyc = 0;
    int   base = 0;
    int   vectors = 0;
    int   miscompares = 0;
    vec_t tbl[$];
    sb_t  sb[$];

    video_pll_reset_sequencer #(
        .NUM_DOMAINS         (3),
        .SYNC_STAGES         (2),
        .PLL_RST_CYCLES      (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .DOMAIN_GAP_CYCLES   (4),
        .MAX_RETRIES         (2)
    ) dut (
        .refclk         (refclk),
        .rst            (rst),
        .pll_locked     (pll_locked),
        .soft_reset_req (soft_reset_req),
        .pll_rst        (pll_rst),
        .domain_rst     (domain_rst),
        .ready          (ready),
        .lock_lost      (lock_lost),
        .retry_count    (retry_count),
        .fail           (fail)
    );

    always #5 refclk = ~refclk;
    always @(posedge refclk) cyc <= cyc + 1;

    function automatic out_t o(logic pr, logic [2:0] dr, logic rdy, logic ll,
                               logic [2:0] rc, logic fl);
        out_t r;
        r.pr = pr; r.dr = dr; r.rdy = rdy; r.ll = ll; r.rc = rc; r.fl = fl;
        return r;
    endfunction

    function automatic out_t cur();
        return o(pll_rst, domain_rst, ready, lock_lost, retry_count, fail);
    endfunction

    task automatic add(bit rs, int d, bit lk, bit sf, int c, out_t e, string nm);
        vec_t v;
        v.rs = rs; v.d = d; v.lk = lk; v.sf = sf; v.c = c; v.e = e; v.nm = nm;
        tbl.push_back(v);
    endtask

    task automatic check(string nm, out_t got, out_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got pr=%b dr=%b rdy=%b ll=%b rc=%0d fl=%b, required pr=%b dr=%b rdy=%b ll=%b rc=%0d fl=%b",
                     nm, cyc - base, got.pr, got.dr, got.rdy, got.ll, got.rc, got.fl,
                     exp.pr, exp.dr, exp.rdy, exp.ll, exp.rc, exp.fl);
        end
    endtask

    // Move to 2 ns after rising edge number k (counted from reset release).
    task automatic goto(int k);
        while (cyc < base + k) begin
            @(posedge refclk);
            #2;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pll_locked = 1'b0;
        soft_reset_req = 1'b0;
        repeat (2) @(posedge refclk);
        #2;
        rst = 1'b0;
        base = cyc;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 300) begin
            @(posedge refclk);
            #2;
            n++;
        end
        if (sb.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic monitor();
        sb_t s;
        forever begin
            @(negedge refclk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                s = sb.pop_front();
                if (s.cyc < cyc) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL %s: sampled late at %0d, required %0d", s.nm, cyc, s.cyc);
                end else begin
                    check(s.nm, cur(), s.e);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        out_t rv;
        sb_t  s;
        rv = o(1'b1, 3'b111, 1'b0, 1'b0, 3'd0, 1'b0);

        // Nominal bring-up, then lock loss in RUN and re-release, then soft reset racing lock drop.
        add(1,  0, 0, 0,  0, rv,                                   "nom_reset");
        add(0,  0, 0, 0,  3, rv,                                   "nom_pllrst_hold");
        add(0,  0, 0, 0,  4, o(0, 3'b111, 0, 0, 0, 0),             "nom_pllrst_low");
        add(0, 10, 1, 0, 20, o(0, 3'b111, 0, 0, 0, 0),             "nom_stable_end");
        add(0, 10, 1, 0, 21, o(0, 3'b110, 0, 0, 0, 0),             "nom_rel0");
        add(0, 10, 1, 0, 24, o(0, 3'b110, 0, 0, 0, 0),             "nom_rel0_hold");
        add(0, 10, 1, 0, 25, o(0, 3'b100, 0, 0, 0, 0),             "nom_rel1");
        add(0, 10, 1, 0, 28, o(0, 3'b100, 0, 0, 0, 0),             "nom_rel1_hold");
        add(0, 10, 1, 0, 29, o(0, 3'b000, 0, 0, 0, 0),             "nom_rel2");
        add(0, 10, 1, 0, 32, o(0, 3'b000, 0, 0, 0, 0),             "nom_pre_ready");
        add(0, 10, 1, 0, 33, o(0, 3'b000, 1, 0, 0, 0),             "nom_ready");
        add(0, 40, 0, 0, 42, o(0, 3'b000, 1, 0, 0, 0),             "loss_sync_delay");
        add(0, 40, 0, 0, 43, o(1, 3'b111, 0, 1, 0, 0),             "loss_react");
        add(0, 44, 1, 0, 46, o(1, 3'b111, 0, 1, 0, 0),             "loss_pllrst");
        add(0, 44, 1, 0, 47, o(0, 3'b111, 0, 1, 0, 0),             "loss_waitlock");
        add(0, 44, 1, 0, 55, o(0, 3'b111, 0, 1, 0, 0),             "loss_stable_end");
        add(0, 44, 1, 0, 56, o(0, 3'b110, 0, 1, 0, 0),             "loss_rel0");
        add(0, 44, 1, 0, 64, o(0, 3'b000, 0, 1, 0, 0),             "loss_rel2");
        add(0, 44, 1, 0, 67, o(0, 3'b000, 0, 1, 0, 0),             "loss_pre_ready");
        add(0, 44, 1, 0, 68, o(0, 3'b000, 1, 1, 0, 0),             "loss_ready_sticky");
        add(0, 70, 0, 0, 72, o(0, 3'b000, 1, 1, 0, 0),             "race_pre");
        add(0, 72, 0, 1, 73, o(1, 3'b111, 0, 0, 0, 0),             "race_soft_wins");
        // Lock flicker during STABLE.
        add(1,  0, 0, 0,  0, rv,                                   "flk_reset");
        add(0, 10, 1, 0, 13, o(0, 3'b111, 0, 0, 0, 0),             "flk_stable");
        add(0, 15, 0, 0, 15, o(0, 3'b111, 0, 0, 0, 0),             "flk_drop");
        add(0, 16, 1, 0, 21, o(0, 3'b111, 0, 0, 0, 0),             "flk_no_release");
        add(0, 16, 1, 0, 26, o(0, 3'b111, 0, 0, 0, 0),             "flk_stable_end");
        add(0, 16, 1, 0, 27, o(0, 3'b110, 0, 0, 0, 0),             "flk_rel0");
        add(0, 16, 1, 0, 38, o(0, 3'b000, 0, 0, 0, 0),             "flk_pre_ready");
        add(0, 16, 1, 0, 39, o(0, 3'b000, 1, 0, 0, 0),             "flk_ready");
        // Lock timeouts, retries, FAIL, then soft reset out of FAIL.
        add(1,  0, 0, 0,  0, rv,                                   "to_reset");
        add(0,  0, 0, 0, 35, o(0, 3'b111, 0, 0, 0, 0),             "to_wait_end");
        add(0,  0, 0, 0, 36, o(1, 3'b111, 0, 0, 1, 0),             "to_retry1");
        add(0,  0, 0, 0, 39, o(1, 3'b111, 0, 0, 1, 0),             "to_retry1_hold");
        add(0,  0, 0, 0, 40, o(0, 3'b111, 0, 0, 1, 0),             "to_retry1_wait");
        add(0,  0, 0, 0, 72, o(1, 3'b111, 0, 0, 2, 0),             "to_retry2");
        add(0,  0, 0, 0, 76, o(0, 3'b111, 0, 0, 2, 0),             "to_retry2_wait");
        add(0,  0, 0, 0,107, o(0, 3'b111, 0, 0, 2, 0),             "to_pre_fail");
        add(0,  0, 0, 0,108, o(0, 3'b111, 0, 0, 2, 1),             "to_fail");
        add(0,  0, 0, 0,130, o(0, 3'b111, 0, 0, 2, 1),             "to_fail_parked");
        add(0,140, 0, 1,141, o(1, 3'b111, 0, 0, 0, 0),             "soft_from_fail");
        add(0,141, 0, 0,145, o(0, 3'b111, 0, 0, 0, 0),             "soft_restart_wait");

        fork
            monitor();
        join_none

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rs) begin
                drain();
                do_reset();
            end
            goto(tbl[i].d);
            pll_locked = tbl[i].lk;
            s.cyc = base + tbl[i].c;
            s.e   = tbl[i].e;
            s.nm  = tbl[i].nm;
            sb.push_back(s);
            if (tbl[i].sf) begin
                soft_reset_req = 1'b1;
                goto(tbl[i].d + 1);
                soft_reset_req = 1'b0;
            end
        end
        drain();

        // Asynchronous reset in the middle of RELEASE.
        do_reset();
        goto(10);
        pll_locked = 1'b1;
        goto(22);
        check("arst_pre", cur(), o(0, 3'b110, 0, 0, 0, 0));
        rst = 1'b1;
        #1;
        check("arst_immediate", cur(), rv);
        @(posedge refclk);
        #2;
        check("arst_held", cur(), rv);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
